// File: rtl/multi_light_shader_if.sv
// Bus bundle for the multi-light shader: job input, light memory read,
// shadow-ray request/response and shaded-pixel output.
interface multi_light_shader_if #(
  parameter int unsigned X_W          = 9,
  parameter int unsigned Y_W          = 8,
  parameter int unsigned LIGHT_ADDR_W = 2,
  parameter int unsigned FACTOR_W     = 8
);
  logic                    job_valid;
  logic                    job_ready;
  logic [X_W-1:0]          job_x;
  logic [Y_W-1:0]          job_y;
  logic                    job_hit;
  logic [15:0]             job_color;
  logic [47:0]             job_point;

  logic [LIGHT_ADDR_W-1:0] light_addr;
  logic [47:0]             light_fwd;

  logic                    ray_valid;
  logic                    ray_ready;
  logic [47:0]             ray_src;
  logic [47:0]             ray_dir;

  logic                    resp_valid;
  logic                    resp_hit;
  logic [FACTOR_W-1:0]     resp_diffuse;

  logic                    pix_valid;
  logic                    pix_ready;
  logic [X_W-1:0]          pix_x;
  logic [Y_W-1:0]          pix_y;
  logic [15:0]             pix_value;

  modport master (
    input  job_valid, job_x, job_y, job_hit, job_color, job_point,
    input  light_fwd, ray_ready, resp_valid, resp_hit, resp_diffuse, pix_ready,
    output job_ready, light_addr, ray_valid, ray_src, ray_dir,
    output pix_valid, pix_x, pix_y, pix_value
  );

  modport slave (
    output job_valid, job_x, job_y, job_hit, job_color, job_point,
    output light_fwd, ray_ready, resp_valid, resp_hit, resp_diffuse, pix_ready,
    input  job_ready, light_addr, ray_valid, ray_src, ray_dir,
    input  pix_valid, pix_x, pix_y, pix_value
  );
endinterface

// File: rtl/multi_light_shader.sv
// Per-pixel lighting sequencer: casts one shadow ray per light, accumulates
// unshadowed diffuse plus ambient, and scales the RGB565 hit colour.
module multi_light_shader #(
  parameter int unsigned NUM_LIGHTS   = 4,
  parameter int unsigned LIGHT_ADDR_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1,
  parameter int unsigned FACTOR_W     = 8,
  parameter int unsigned AMBIENT      = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned X_W          = 9,
  parameter int unsigned Y_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shadows_en,
  input  logic [15:0]          background,
  multi_light_shader_if.master bus,
  output logic                 busy
);
  localparam int unsigned ACC_W  = FACTOR_W + 1 + $clog2(NUM_LIGHTS + 2);
  localparam int unsigned EFF_W  = FACTOR_W + 1;
  localparam int unsigned PROD_W = 6 + EFF_W;
  localparam int unsigned CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam logic [47:0]      SIGN_MASK = 48'h8000_8000_8000;
  localparam logic [ACC_W-1:0] ONE       = ACC_W'(1) << FACTOR_W;

  typedef enum logic [2:0] {IDLE, FETCH, CAST, WAIT_RESP, SHADE, OUTPUT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   lat_cnt;
  logic [ACC_W-1:0]   acc;
  logic [15:0]        color_q;
  logic [47:0]        point_q;
  logic               last_light_c;
  logic [EFF_W-1:0]   eff_c;
  logic [15:0]        shade_c;

  assign last_light_c = (bus.light_addr == LIGHT_ADDR_W'(NUM_LIGHTS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (bus.job_valid) state_nxt = bus.job_hit ? FETCH : OUTPUT;
      FETCH:     if (lat_cnt == CNT_W'(MEM_LATENCY - 1)) state_nxt = CAST;
      CAST:      if (bus.ray_ready) state_nxt = WAIT_RESP;
      WAIT_RESP: if (bus.resp_valid) state_nxt = last_light_c ? SHADE : FETCH;
      SHADE:     state_nxt = OUTPUT;
      OUTPUT:    if (bus.pix_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Clamp intensity to 1.0 and scale each colour channel by it
  always_comb begin
    eff_c   = (acc > ONE) ? EFF_W'(ONE) : EFF_W'(acc);
    shade_c = {5'((PROD_W'(color_q[15:11]) * PROD_W'(eff_c)) >> FACTOR_W),
               6'((PROD_W'(color_q[10:5])  * PROD_W'(eff_c)) >> FACTOR_W),
               5'((PROD_W'(color_q[4:0])   * PROD_W'(eff_c)) >> FACTOR_W)};
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.job_ready  <= 1'b1;
      bus.ray_valid  <= 1'b0;
      bus.pix_valid  <= 1'b0;
      busy           <= 1'b0;
      bus.light_addr <= '0;
      bus.ray_src    <= '0;
      bus.ray_dir    <= '0;
      bus.pix_x      <= '0;
      bus.pix_y      <= '0;
      bus.pix_value  <= '0;
      lat_cnt        <= '0;
      acc            <= '0;
      color_q        <= '0;
      point_q        <= '0;
    end else begin
      bus.job_ready <= (state_nxt == IDLE);
      bus.ray_valid <= (state_nxt == CAST);
      bus.pix_valid <= (state_nxt == OUTPUT);
      busy          <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (bus.job_valid) begin
            bus.pix_x <= X_W'(bus.job_x);
            bus.pix_y <= Y_W'(bus.job_y);
            color_q   <= bus.job_color;
            point_q   <= bus.job_point;
            if (!bus.job_hit) begin
              bus.pix_value <= background;
            end else begin
              acc            <= ACC_W'(AMBIENT);
              bus.light_addr <= '0;
              lat_cnt        <= '0;
            end
          end
        end
        FETCH: begin
          if (lat_cnt == CNT_W'(MEM_LATENCY - 1)) begin
            bus.ray_dir <= bus.light_fwd ^ SIGN_MASK;
            bus.ray_src <= point_q;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        WAIT_RESP: begin
          if (bus.resp_valid) begin
            if (!(shadows_en && bus.resp_hit)) acc <= acc + ACC_W'(bus.resp_diffuse);
            if (!last_light_c) begin
              bus.light_addr <= bus.light_addr + LIGHT_ADDR_W'(1);
              lat_cnt        <= '0;
            end
          end
        end
        SHADE:   bus.pix_value <= shade_c;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_light_shader.sv
// Directed bench for multi_light_shader: reactive light memory and raycaster,
// a spec-level shading model, and a per-cycle output compare process.
module tb_multi_light_shader;
  localparam int unsigned NL  = 2;
  localparam int unsigned LAW = 1;
  localparam int unsigned FW  = 8;
  localparam int unsigned AMB = 32;
  localparam int unsigned ML  = 2;
  localparam int unsigned XW  = 9;
  localparam int unsigned YW  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shadows_en = 1'b0;
  logic [15:0] background = 16'h0;
  logic        busy;

  multi_light_shader_if #(.X_W(XW), .Y_W(YW), .LIGHT_ADDR_W(LAW), .FACTOR_W(FW)) bus ();

  multi_light_shader #(
    .NUM_LIGHTS(NL), .LIGHT_ADDR_W(LAW), .FACTOR_W(FW), .AMBIENT(AMB),
    .MEM_LATENCY(ML), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk(clk), .rst(rst), .shadows_en(shadows_en), .background(background),
    .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0, n_pass = 0;
  logic [47:0]   fwd_tab  [NL];
  logic [FW-1:0] diff_tab [NL];
  logic          hit_tab  [NL];
  logic [47:0]   seen_dir [NL];
  logic [32:0]   exp_pix [$];
  logic [96:0]   exp_ray [$];
  int unsigned   pix_hs_cnt = 0, rays_seen = 0, resp_pulses = 0;
  logic [15:0]   last_pix = '0;
  int unsigned   ray_stall = 0, pix_stall = 0, resp_delay = 0, pend = 0;
  logic [LAW-1:0] pend_addr = '0;
  bit            no_expect = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic note_fail(input string nm);
    n_chk++;
    $display("FAIL %s: event not seen / not allowed", nm);
  endtask

  // Shadow rays point back toward each light: negate every float16 component
  function automatic logic [47:0] neg_vec(input logic [47:0] v);
    return {~v[47], v[46:32], ~v[31], v[30:16], ~v[15], v[14:0]};
  endfunction

  function automatic logic [15:0] model_pix(input logic hit, input logic [15:0] c);
    int inten, r, g, b;
    if (!hit) return background;
    inten = AMB;
    for (int i = 0; i < NL; i++)
      if (!(shadows_en && hit_tab[i])) inten += int'(diff_tab[i]);
    if (inten > 256) inten = 256;
    r = int'(c[15:11]) * inten / 256;
    g = int'(c[10:5])  * inten / 256;
    b = int'(c[4:0])   * inten / 256;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  // Light memory: address registered once, so data is ready ML=2 edges after a change
  logic [LAW-1:0] addr_q;
  always @(posedge clk) addr_q <= bus.light_addr;
  assign bus.light_fwd = fwd_tab[addr_q];

  // Raycaster and pixel sink with programmable stalls and response delay
  always @(posedge clk) begin
    #2;
    bus.resp_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.resp_valid   = 1'b1;
        bus.resp_hit     = hit_tab[pend_addr];
        bus.resp_diffuse = diff_tab[pend_addr];
        resp_pulses++;
      end
    end
    if (bus.ray_valid && !rst) begin
      if (ray_stall > 0) begin
        bus.ray_ready = 1'b0;
        ray_stall--;
      end else begin
        bus.ray_ready = 1'b1;
        pend      = resp_delay + 1;
        pend_addr = bus.light_addr;
        rays_seen++;
      end
    end else begin
      bus.ray_ready = 1'b0;
    end
    if (bus.pix_valid && pix_stall > 0) begin
      bus.pix_ready = 1'b0;
      pix_stall--;
    end else begin
      bus.pix_ready = 1'b1;
    end
  end

  // Per-cycle compare against the expectation queues
  logic prev_rv = 0, prev_rhs = 0, prev_pv = 0, prev_phs = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 0; prev_rhs = 0; prev_pv = 0; prev_phs = 0;
    end else begin
      if (prev_rv && !prev_rhs) chk("ray_valid_held", bus.ray_valid, 1'b1);
      if (prev_pv && !prev_phs) chk("pix_valid_held", bus.pix_valid, 1'b1);
      if (bus.ray_valid) begin
        chk("busy_in_cast", busy, 1'b1);
        if (exp_ray.size() == 0) note_fail("unexpected_ray");
        else begin
          chk("ray_addr_src_dir", {bus.light_addr, bus.ray_src, bus.ray_dir}, exp_ray[0]);
          if (bus.ray_ready) begin
            seen_dir[bus.light_addr] = bus.ray_dir;
            void'(exp_ray.pop_front());
          end
        end
      end
      if (bus.pix_valid) begin
        chk("job_ready_in_output", bus.job_ready, 1'b0);
        chk("busy_in_output", busy, 1'b1);
        if (exp_pix.size() == 0) note_fail("unexpected_pixel");
        else begin
          chk("pix_xy_value", {bus.pix_x, bus.pix_y, bus.pix_value}, exp_pix[0]);
          if (bus.pix_ready) begin
            last_pix = bus.pix_value;
            pix_hs_cnt++;
            void'(exp_pix.pop_front());
          end
        end
      end
      prev_rv  = bus.ray_valid;
      prev_rhs = bus.ray_valid && bus.ray_ready;
      prev_pv  = bus.pix_valid;
      prev_phs = bus.pix_valid && bus.pix_ready;
    end
  end

  task automatic send_job(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic hit,
                          input logic [15:0] color, input logic [47:0] point, input int exp_lat);
    int n, lat;
    if (!no_expect) begin
      exp_pix.push_back({x, y, model_pix(hit, color)});
      if (hit) for (int i = 0; i < NL; i++) exp_ray.push_back({LAW'(i), point, neg_vec(fwd_tab[i])});
    end
    bus.job_valid = 1'b1; bus.job_x = x; bus.job_y = y; bus.job_hit = hit;
    bus.job_color = color; bus.job_point = point;
    n = 0;
    while (!bus.job_ready && n < 300) begin @(posedge clk); #3; n++; end
    if (!bus.job_ready) begin note_fail("job_accept_timeout"); bus.job_valid = 1'b0; return; end
    @(posedge clk); #3;
    bus.job_valid = 1'b0;
    if (exp_lat > 0) begin
      lat = 1;
      while (!bus.pix_valid && lat < 300) begin @(posedge clk); #3; lat++; end
      chk("latency", lat, exp_lat);
    end
  endtask

  task automatic wait_pix(input int unsigned target);
    int n = 0;
    while (pix_hs_cnt < target && n < 500) begin @(posedge clk); #3; n++; end
    chk("pixel_count", pix_hs_cnt, target);
    @(posedge clk); #3;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_job_ready"}, bus.job_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ray_valid"}, bus.ray_valid, 1'b0);
    chk({tag, "_pix_valid"}, bus.pix_valid, 1'b0);
    chk({tag, "_light_addr"}, bus.light_addr, '0);
    chk({tag, "_pix_xyv"}, {bus.pix_x, bus.pix_y, bus.pix_value}, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, rbase, pbase;
    int n;
    fwd_tab[0] = 48'h3C00_0000_BC00;
    fwd_tab[1] = 48'h0000_3C00_4000;
    diff_tab[0] = 8'd128; diff_tab[1] = 8'd64;
    hit_tab[0] = 1'b0;    hit_tab[1] = 1'b0;
    bus.job_valid = 1'b0; bus.job_x = '0; bus.job_y = '0; bus.job_hit = 1'b0;
    bus.job_color = '0;   bus.job_point = '0;
    repeat (3) @(posedge clk);
    #3;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #3;

    // Primary miss: background the cycle after accept, no rays
    background = 16'h1234;
    rbase = rays_seen; pbase = pix_hs_cnt;
    send_job(9'd3, 8'd4, 1'b0, 16'hFFFF, 48'h0, 1);
    wait_pix(pbase + 1);
    chk("miss_pix", last_pix, 16'h1234);
    chk("miss_no_rays", rays_seen - rbase, 0);

    // Two lit lights, no occlusion
    shadows_en = 1'b1;
    rbase = rays_seen; pbase = pix_hs_cnt;
    send_job(9'd10, 8'd20, 1'b1, 16'hFFFF, 48'h1111_2222_3333, 10);
    wait_pix(pbase + 1);
    chk("lit_pix", last_pix, 16'hDEFB);
    chk("lit_rays", rays_seen - rbase, 2);
    chk("lit_dir0", seen_dir[0], 48'hBC00_8000_3C00);
    chk("lit_dir1", seen_dir[1], 48'h8000_BC00_C000);

    // Light 1 occluded, then the same with shadows disabled
    hit_tab[1] = 1'b1;
    pbase = pix_hs_cnt;
    send_job(9'd511, 8'd255, 1'b1, 16'hFFFF, 48'hABCD_0123_4567, 10);
    wait_pix(pbase + 1);
    chk("shadow_pix", last_pix, 16'h9CF3);
    shadows_en = 1'b0;
    send_job(9'd0, 8'd1, 1'b1, 16'hFFFF, 48'h0F0F_F0F0_5A5A, 10);
    wait_pix(pbase + 2);
    chk("noshadow_pix", last_pix, 16'hDEFB);

    // Saturation clamps intensity to 1.0
    hit_tab[1] = 1'b0;
    diff_tab[0] = 8'd255; diff_tab[1] = 8'd255;
    pbase = pix_hs_cnt;
    send_job(9'd100, 8'd50, 1'b1, 16'hFFFF, 48'h1, 10);
    wait_pix(pbase + 1);
    chk("sat_pix", last_pix, 16'hFFFF);

    // Mid-grey colour, light 0 occluded: intensity 92/256
    shadows_en = 1'b1;
    hit_tab[0] = 1'b1; hit_tab[1] = 1'b0;
    diff_tab[0] = 8'd100; diff_tab[1] = 8'd60;
    pbase = pix_hs_cnt;
    send_job(9'd7, 8'd9, 1'b1, 16'h8410, 48'h2, 10);
    wait_pix(pbase + 1);
    chk("grey_pix", last_pix, 16'h2965);

    // Back-pressure on ray and pixel, second job queued behind the first
    hit_tab[0] = 1'b0;
    diff_tab[0] = 8'd128; diff_tab[1] = 8'd64;
    ray_stall = 5; pix_stall = 4;
    pbase = pix_hs_cnt;
    send_job(9'd33, 8'd44, 1'b1, 16'hFFFF, 48'hDEAD_BEEF_CAFE, 0);
    send_job(9'd34, 8'd45, 1'b0, 16'h0, 48'h0, 0);
    chk("second_job_after_pixel", pix_hs_cnt, pbase + 1);
    chk("bp_first_pix", last_pix, 16'hDEFB);
    chk("bp_stalls_consumed", ray_stall + pix_stall, 0);
    wait_pix(pbase + 2);
    chk("bp_second_pix", last_pix, 16'h1234);

    // Reset while waiting for a response; late response must be ignored
    resp_delay = 8;
    no_expect = 1;
    exp_ray.push_back({LAW'(0), 48'h7777_8888_9999, neg_vec(fwd_tab[0])});
    base = resp_pulses; pbase = pix_hs_cnt;
    send_job(9'd1, 8'd2, 1'b1, 16'hFFFF, 48'h7777_8888_9999, 0);
    no_expect = 0;
    n = 0;
    while (exp_ray.size() > 0 && n < 100) begin @(posedge clk); #3; n++; end
    chk("rst_ray0_issued", exp_ray.size(), 0);
    rst = 1'b1;
    @(posedge clk); #3;
    check_reset_vals("midrst");
    rst = 1'b0;
    resp_delay = 0;
    repeat (12) @(posedge clk);
    #3;
    chk("late_resp_seen", resp_pulses - base, 1);
    chk("late_resp_busy", busy, 1'b0);
    chk("late_resp_no_pixel", pix_hs_cnt, pbase);

    // Normal job after reset
    send_job(9'd200, 8'd100, 1'b1, 16'hFFFF, 48'h3, 10);
    wait_pix(pbase + 1);
    chk("post_rst_pix", last_pix, 16'hDEFB);

    chk("pix_queue_drained", exp_pix.size(), 0);
    chk("ray_queue_drained", exp_ray.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/multi_light_shader.md
Name: multi_light_shader

Overview:
- Per-pixel lighting sequencer that sits between the primary-ray stage and the framebuffer writer.
- For each primary-ray hit, it walks the NUM_LIGHTS entries in light memory and issues one shadow ray per light to the shared raycaster over a valid/ready handshake.
- It sums the diffuse factors of unshadowed lights plus an ambient term, scales the RGB565 hit colour, and emits one shaded pixel per accepted job.
- Generalises the single-directional-light, shadow-only flow to N lights, fixed-point intensity accumulation, and full back-pressure on every interface.

Parameters:
- NUM_LIGHTS, 4, number of lights iterated per pixel (>=1).
- LIGHT_ADDR_W, $clog2(NUM_LIGHTS) (min 1), light memory address width.
- FACTOR_W, 8, fractional bits of unsigned diffuse/ambient factors. 1.0 = 2^FACTOR_W.
- AMBIENT, 32, ambient factor added once per hit pixel (Q0.FACTOR_W).
- MEM_LATENCY, 2, cycles from light_addr change to light_fwd valid (>=1).
- X_W, 9, pixel x width.
- Y_W, 8, pixel y width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- shadows_en  in  1  1 = shadowed lights contribute 0; 0 = resp_hit ignored
- background  in  16  RGB565 value output for primary misses
- job_valid  in  1  primary-ray result valid
- job_ready  out  1  block can accept a job
- job_x  in  X_W  pixel x
- job_y  in  Y_W  pixel y
- job_hit  in  1  primary ray hit a shape
- job_color  in  16  RGB565 colour of the hit shape
- job_point  in  48  intersection point, vec3 of float16 {z,y,x}
- light_addr  out  LIGHT_ADDR_W  light memory read address
- light_fwd  in  48  light forward vector, vec3 float16
- ray_valid  out  1  shadow-ray request valid
- ray_ready  in  1  raycaster accepts the request
- ray_src  out  48  shadow-ray origin
- ray_dir  out  48  shadow-ray direction
- resp_valid  in  1  raycaster result valid (single-cycle pulse)
- resp_hit  in  1  shadow ray was occluded
- resp_diffuse  in  FACTOR_W  clamped n·l for this light, Q0.FACTOR_W
- pix_valid  out  1  shaded pixel valid
- pix_ready  in  1  downstream accepts pixel
- pix_x  out  X_W  pixel x
- pix_y  out  Y_W  pixel y
- pix_value  out  16  RGB565 result
- busy  out  1  state != IDLE

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Reset values: state=IDLE, job_ready=1, ray_valid=0, pix_valid=0, light_addr=0, pix_x=0, pix_y=0, pix_value=0, accumulator=0.
- States: IDLE, FETCH, CAST, WAIT_RESP, SHADE, OUTPUT.
- IDLE: job_ready=1. When job_valid is high, latch x, y, colour and point.
  - job_hit=0: pix_value<=background, go to OUTPUT.
  - job_hit=1: acc<=AMBIENT, light_addr<=0, start the latency counter, go to FETCH.
- FETCH: wait MEM_LATENCY cycles, then latch ray_dir = light_fwd with each component's sign bit inverted, ray_src = latched point. Go to CAST.
- CAST: ray_valid=1; src/dir stay stable until ray_valid&&ray_ready, then go to WAIT_RESP.
  - ray_valid must never drop before the handshake completes.
- WAIT_RESP: on resp_valid, if !(shadows_en&&resp_hit) then acc<=acc+resp_diffuse.
  - If light_addr==NUM_LIGHTS-1, go to SHADE.
  - Otherwise light_addr<=light_addr+1 and go to FETCH.
  - resp_valid outside WAIT_RESP is ignored.
- Accumulator:
  - Width FACTOR_W+1+$clog2(NUM_LIGHTS+2); it must not wrap.
  - SHADE clamps eff = min(acc, 2^FACTOR_W).
- SHADE (1 cycle):
  - Channels r=c[15:11], g=c[10:5], b=c[4:0]; each ch' = (ch*eff)>>FACTOR_W (truncate).
  - pix_value={r',g',b'}. Go to OUTPUT.
  - Since eff<=1.0, no channel can exceed its input.
- OUTPUT: pix_valid=1; pix_x, pix_y and pix_value are held stable while pix_ready=0. On pix_valid&&pix_ready go to IDLE. job_ready=0 in every state except IDLE.
- Latency with ready/response in zero wait:
  - Miss: pix_valid asserts the cycle after acceptance.
  - Hit: 1 + NUM_LIGHTS*(MEM_LATENCY+2) + 1 cycles, plus raycaster response time.
- Reset mid-operation: all outputs return to reset values on the next edge. A late resp_valid after reset is ignored (state is IDLE).
- light_addr changes only on job acceptance or light advance.

Test Plan:
- Miss: NUM_LIGHTS=2, background=16'h1234, job_hit=0 -> one pixel 16'h1234 the cycle after accept; ray_valid never asserts.
- Lit, no shadows: NUM_LIGHTS=2, FACTOR_W=8, AMBIENT=32, colour 16'hFFFF, resp_diffuse 128 then 64, resp_hit=0 -> exactly 2 rays, light_addr 0 then 1, pix_value=16'hDEFB.
- Shadowed: same job, light 1 resp_hit=1, shadows_en=1 -> 16'h9CF3. Same stimulus with shadows_en=0 -> 16'hDEFB.
- Saturation: diffuse 255,255 with colour 16'hFFFF -> acc clamped to 256, pix_value=16'hFFFF.
- Back-pressure:
  - ray_ready low 5 cycles -> ray_valid/src/dir held.
  - pix_ready low 4 cycles -> pix_valid/pix_value held, job_ready=0.
  - Next job accepted only after pixel handshake.
- Reset in WAIT_RESP, then resp_valid pulse -> busy=0, no pixel emitted, next job shades normally.
